pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Downstream consumer of the next-PC stage: holds the architectural PC register and runs the instruction-memory fetch handshake.
- Presents the fetched instruction to the datapath.
- Loads the next-PC value when the datapath acknowledges the current instruction.
- Allows the single-cycle core to run against a variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (text segment base).
- IM_BYTES, 16384, size in bytes of the legal instruction address window starting at RESET_PC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- npc  in  32  next PC from the next-PC stage, sampled on instr_ack
- instr_ack  in  1  datapath has consumed instr; advance PC
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word returned by memory
- pc  out  32  address of the instruction currently held or being fetched
- instr  out  32  registered instruction word
- instr_valid  out  1  instr is valid for pc
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address of the request; always equals pc
- instret  out  32  count of acknowledged instructions
- fetch_fault  out  1  sticky fault flag (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, and wins over every other input in the same edge.
  - Reset values: pc=RESET_PC, instr=0, instr_valid=0, instret=0, fetch_fault=0, state=S_REQ.
- Reset mid-fetch abandons the outstanding request. The memory must drop it; a stray rvalid is ignored because state is S_REQ.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_FAULT.
- S_REQ:
  - imem_req=1.
  - imem_ready=1 with imem_rvalid=0: go to S_WAIT.
  - imem_ready=1 with imem_rvalid=1 (zero-latency memory): capture instr, set instr_valid, go to S_HOLD.
  - imem_ready=0: stay.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, go to S_HOLD.
  - imem_rdata is ignored when rvalid=0.
- S_HOLD:
  - instr and instr_valid are stable. imem_req=0.
  - instr_ack=1: pc<=next_pc, instr_valid<=0, instret<=instret+1 (wraps modulo 2^32), go to S_REQ.
  - instr_ack is ignored in any other state.
- next_pc = {npc[31:2],2'b00}. Low bits are always forced to zero.
- Throughput: 2 cycles per instruction minimum with zero-latency memory (S_REQ, S_HOLD). Latency L adds L cycles.
- instr_valid is a registered output and rises the cycle after the capturing edge.
- imem_addr=pc combinationally. pc changes only on the ack edge.
- S_FAULT: imem_req=0, instr_valid=0, no state change until reset.

Optional Feature:
- Macro: PC_FETCH_ADDR_CHECK_EN.
- Defined:
  - On instr_ack, the raw npc is checked before loading.
  - The check fails if npc[1:0]!=0, npc<RESET_PC, or npc>=RESET_PC+IM_BYTES.
  - On failure: pc<=raw npc (kept for debug), fetch_fault<=1, instret still increments, go to S_FAULT.
  - The reset PC itself is not checked.
- Not defined: no check; fetch_fault is tied to 0; S_FAULT is unreachable and may be omitted.

Decomposition:
- Shared package (cpu_defs):
  - state encoding localparams S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2, S_FAULT=2'd3
  - RESET_PC default constant 32'h0000_3000
  - instruction width 32
- No sub-module is required; the FSM, PC register and counter stay in one module.
- The optional range checker may be a small combinational helper, pc_range_check, instantiated only under the macro.

Test Plan:
- Reset sequencing: assert reset 3 cycles, then release with imem_ready=1, imem_rvalid=1, rdata=32'h3c01_1234.
  - Required: imem_req=1 and imem_addr=32'h3000 in the first cycle.
  - instr=32'h3c01_1234 and instr_valid=1 the next cycle.
  - instret=0.
- 3-cycle latency: ready at request, rvalid 3 cycles later.
  - imem_req drops after the handshake.
  - instr_valid rises exactly 1 cycle after rvalid.
  - Data seen before rvalid is never captured.
- Delayed ack: hold instr_ack=0 for 5 cycles, then pulse it with npc=32'h3004.
  - instr is stable throughout; instret=1; next imem_addr=32'h3004.
- Branch/jump: ack with npc=32'h3020, then npc=32'h3003.
  - pc=32'h3020, then pc=32'h3000 (low bits masked when the macro is off).
- Reset mid-operation: reset while in S_WAIT, with rvalid arriving the same cycle.
  - pc=RESET_PC, instr_valid=0, instr not updated.
- Macro on: ack with npc=32'h0000_7000.
  - fetch_fault=1, pc=32'h7000, imem_req stays 0 for 10 cycles.
  - Reset clears the fault.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage: FSM state encoding, reset PC and
// instruction width, plus the word-alignment helper applied to the next PC.
package cpu_defs;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_range_check.sv
// Combinational legality check for a candidate PC: word aligned and inside
// the instruction window [BASE, BASE+BYTES). Used only with PC_FETCH_ADDR_CHECK_EN.
module pc_range_check #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned BYTES = 16384
) (
  input  logic [31:0] i_addr,
  output logic        o_ok
);

  // Limit is computed one bit wider so a window ending at 2^32 does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(BYTES);

  logic w_aligned;
  logic w_above_base;
  logic w_below_limit;

  assign w_aligned     = (i_addr[1:0] == 2'b00);
  assign w_above_base  = (i_addr >= BASE);
  assign w_below_limit = ({1'b0, i_addr} < LIMIT);
  assign o_ok          = w_aligned & w_above_base & w_below_limit;

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus instruction-memory fetch handshake.
// Optional next-PC legality check and sticky fault: PC_FETCH_ADDR_CHECK_EN.
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_BYTES = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        npc,
  input  logic               instr_ack,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  output logic [31:0]        instret,
  output logic               fetch_fault
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [31:0]        r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic [31:0]        r_instret;
  logic               r_fault;

  logic               w_capture;
  logic               w_advance;
  logic               w_npc_bad;

`ifdef PC_FETCH_ADDR_CHECK_EN
  logic w_npc_ok;

  pc_range_check #(
    .BASE  (RESET_PC),
    .BYTES (IM_BYTES)
  ) u_range_check (
    .i_addr (npc),
    .o_ok   (w_npc_ok)
  );

  assign w_npc_bad = ~w_npc_ok;
`else
  // Without the checker the low npc bits and window size are don't-cares.
  logic w_unused_cfg;
  assign w_unused_cfg = &{1'b0, npc[1:0], IM_BYTES[0]};
  assign w_npc_bad    = 1'b0;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    imem_req    = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (imem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          w_advance   = 1'b1;
          w_state_nxt = w_npc_bad ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset wins over capture/advance, so a response landing on the reset
  // edge is dropped and any outstanding request is abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_instret     <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_advance) begin
        r_pc          <= w_npc_bad ? npc : align_word(npc);
        r_instr_valid <= 1'b0;
        r_instret     <= r_instret + 32'd1;
        if (w_npc_bad) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign instret     = r_instret;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a small memory responder drives
// fetches, expected words are queued when returned and popped on capture.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        instr_ack;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instret;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  logic [31:0] last_instr;

  pc_fetch_unit #(
    .RESET_PC (RPC),
    .IM_BYTES (16384)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .instr_ack   (instr_ack),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instret     (instret),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // One fetch from S_REQ: rvalid arrives lat cycles after the accepted request.
  task automatic fetch(input int lat, input logic [31:0] data);
    exp_t e;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    if (lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      e.pc = exp_pc;
      e.instr = data;
      sb.push_back(e);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = ~data;
    end
    step();
    imem_ready = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_wait[%0d]: req=%b valid=%b, expected req=0 valid=0", c, imem_req, instr_valid);
      end
      if (c == lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        e.pc = exp_pc;
        e.instr = data;
        sb.push_back(e);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = data ^ 32'(c * 32'h0101_0101);
      end
      step();
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hbad0_bad0;
    n_checks++;
    if (instr_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_valid: valid=%b queued=%0d, expected valid=1 with a queued word", instr_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (instr !== e.instr || pc !== e.pc || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_data: instr=%h pc=%h req=%b, expected instr=%h pc=%h req=0", instr, pc, imem_req, e.instr, e.pc);
      end
    end
    last_instr = data;
  endtask

  // Acknowledge from S_HOLD and check the PC/counter update.
  task automatic ack(input logic [31:0] nv, input logic [31:0] want_pc);
    instr_ack = 1'b1;
    npc       = nv;
    step();
    instr_ack = 1'b0;
    exp_pc      = want_pc;
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (pc !== want_pc || imem_addr !== want_pc || instret !== exp_instret ||
        instr_valid !== 1'b0 || imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ack(%h): pc=%h addr=%h instret=%0d valid=%b req=%b fault=%b, expected pc=addr=%h instret=%0d valid=0 req=1 fault=0",
               nv, pc, imem_addr, instret, instr_valid, imem_req, fetch_fault, want_pc, exp_instret);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    npc = '0;
    instr_ack = 1'b0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3c01_1234;
    repeat (3) step();
    n_checks++;
    if (pc !== RPC || instr !== 32'h0 || instr_valid !== 1'b0 || instret !== 32'h0 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h instr=%h valid=%b instret=%0d fault=%b, expected pc=%h rest 0",
               pc, instr, instr_valid, instret, fetch_fault, RPC);
    end
    reset = 1'b0;
    exp_pc = RPC;
    exp_instret = '0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=00003000", imem_req, imem_addr);
    end
    e.pc = RPC;
    e.instr = 32'h3c01_1234;
    sb.push_back(e);
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (instr !== e.instr || instr_valid !== 1'b1 || instret !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_fetch: instr=%h valid=%b instret=%0d, expected instr=%h valid=1 instret=0",
               instr, instr_valid, instret, e.instr);
    end
    last_instr = 32'h3c01_1234;
  endtask

  task automatic test_delayed_ack();
    for (int c = 0; c < 5; c++) begin
      npc = 32'h0000_5550 + 32'(c);
      step();
      n_checks++;
      if (instr !== last_instr || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL hold[%0d]: instr=%h valid=%b req=%b pc=%h, expected instr=%h valid=1 req=0 pc=%h",
                 c, instr, instr_valid, imem_req, pc, last_instr, exp_pc);
      end
    end
    ack(32'h0000_3004, 32'h0000_3004);
  endtask

  task automatic test_latency();
    imem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL stall[%0d]: req=%b addr=%h, expected req=1 addr=%h", c, imem_req, imem_addr, exp_pc);
      end
    end
    fetch(3, 32'h2402_0005);
  endtask

  task automatic test_branch();
    ack(32'h0000_3020, 32'h0000_3020);
    fetch(1, 32'h0c00_0c01);
`ifndef PC_FETCH_ADDR_CHECK_EN
    ack(32'h0000_3003, 32'h0000_3000);
`else
    ack(32'h0000_3008, 32'h0000_3008);
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      fetch(0, 32'h1000_0000 + 32'(k));
      ack(32'h0000_3100 + 32'(k * 4), 32'h0000_3100 + 32'(k * 4));
    end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait: req=%b, expected 0", imem_req);
    end
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hdead_beef;
    step();
    reset = 1'b0;
    exp_pc = RPC;
    exp_instret = '0;
    n_checks++;
    if (pc !== RPC || instr_valid !== 1'b0 || instr !== 32'h0 || instret !== 32'h0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: pc=%h valid=%b instr=%h instret=%0d req=%b, expected pc=%h valid=0 instr=0 instret=0 req=1",
               pc, instr_valid, instr, instret, imem_req, RPC);
    end
    imem_rvalid = 1'b0;
    step();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stray: valid=%b req=%b, expected valid=0 req=1", instr_valid, imem_req);
    end
    fetch(2, 32'h8c08_0000);
    ack(32'h0000_3010, 32'h0000_3010);
  endtask

`ifdef PC_FETCH_ADDR_CHECK_EN
  task automatic test_fault();
    fetch(0, 32'h0000_000c);
    instr_ack = 1'b1;
    npc = 32'h0000_7000;
    step();
    instr_ack = 1'b0;
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (fetch_fault !== 1'b1 || pc !== 32'h0000_7000 || instret !== exp_instret) begin
      n_fail++;
      $display("FAIL fault_entry: fault=%b pc=%h instret=%0d, expected fault=1 pc=00007000 instret=%0d",
               fetch_fault, pc, instret, exp_instret);
    end
    imem_ready = 1'b1;
    imem_rvalid = 1'b1;
    instr_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1 || pc !== 32'h0000_7000) begin
        n_fail++;
        $display("FAIL fault_hold[%0d]: req=%b valid=%b fault=%b pc=%h, expected req=0 valid=0 fault=1 pc=00007000",
                 c, imem_req, instr_valid, fetch_fault, pc);
      end
      step();
    end
    instr_ack = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_pc = RPC;
    exp_instret = '0;
    n_checks++;
    if (fetch_fault !== 1'b0 || pc !== RPC || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b pc=%h req=%b, expected fault=0 pc=%h req=1", fetch_fault, pc, imem_req, RPC);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_delayed_ack();
    test_latency();
    test_branch();
    test_back_to_back();
    test_reset_mid();
`ifdef PC_FETCH_ADDR_CHECK_EN
    test_fault();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected words never captured, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
